dp_bram_fifo: RTL and testbench

DP_BRAM_FIFO -- requirements
Module: dp_bram_fifo

---
 rtl/dp_bram_fifo_pkg.sv | 17 +
 rtl/dp_bram_fifo_if.sv | 49 ++++
 rtl/dp_bram.sv | 38 +++
 rtl/dp_bram_fifo.sv | 132 +++++++++++++
 tb/tb_dp_bram_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dp_bram_fifo_pkg.sv
// Shared constants and sizing helpers for the block-RAM FIFO.
package dp_bram_fifo_pkg;

  // Storage granularity in bits: one iCE40 4 kbit block RAM.
  localparam int SIZE_GRANULE = 4096;

  // Number of WIDTH-bit words held by SIZE bits of storage.
  function automatic int fifo_depth(input int size, input int width);
    return size / width;
  endfunction

  // Pointer width needed to address fifo_depth() words.
  function automatic int fifo_addrw(input int size, input int width);
    return $clog2(size / width);
  endfunction

endpackage

// File: rtl/dp_bram_fifo_if.sv
// Producer/consumer handshake bundle for dp_bram_fifo.
// The master side pushes, pops and flushes; the slave side is the FIFO.
interface dp_bram_fifo_if
  import dp_bram_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SIZE  = SIZE_GRANULE
);

  localparam int ADDRW = fifo_addrw(SIZE, WIDTH);

  logic             flush_in;
  logic             push_in;
  logic [WIDTH-1:0] push_data_in;
  logic             push_ready_out;
  logic             pop_valid_out;
  logic [WIDTH-1:0] pop_data_out;
  logic             pop_in;
  logic [ADDRW:0]   count_out;
  logic             afull_out;
  logic             overflow_out;

  modport master (
    output flush_in,
    output push_in,
    output push_data_in,
    output pop_in,
    input  push_ready_out,
    input  pop_valid_out,
    input  pop_data_out,
    input  count_out,
    input  afull_out,
    input  overflow_out
  );

  modport slave (
    input  flush_in,
    input  push_in,
    input  push_data_in,
    input  pop_in,
    output push_ready_out,
    output pop_valid_out,
    output pop_data_out,
    output count_out,
    output afull_out,
    output overflow_out
  );

endinterface

// File: rtl/dp_bram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Written so that synthesis maps it onto iCE40 block RAM.
module dp_bram
  import dp_bram_fifo_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int SIZE  = SIZE_GRANULE,
  localparam int DEPTH = fifo_depth(SIZE, WIDTH),
  localparam int ADDRW = fifo_addrw(SIZE, WIDTH)
) (
  input  logic             clk_in,
  input  logic             wr_en_in,
  input  logic [ADDRW-1:0] wr_addr_in,
  input  logic [WIDTH-1:0] wr_data_in,
  input  logic [ADDRW-1:0] rd_addr_in,
  output logic [WIDTH-1:0] rd_data_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port: store one word per enabled edge.
  // NOTE: the array has no reset; resetting it would prevent BRAM inference,
  // and the FIFO never presents a location it has not written since reset.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem_q[wr_addr_in] <= wr_data_in;
    end
  end

  // Read port: registered read every cycle; a same-edge write is not forwarded.
  always_ff @(posedge clk_in) begin
    rd_data_q <= mem_q[rd_addr_in];
  end

  assign rd_data_out = rd_data_q;

endmodule

// File: rtl/dp_bram_fifo.sv
// First-word-fall-through FIFO on a synchronous-read block RAM.
// All control state (pointers, fill count, output valid, flags) lives here;
// dp_bram only stores words.
module dp_bram_fifo
  import dp_bram_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIZE      = SIZE_GRANULE,
  parameter int AFULL_LVL = fifo_depth(SIZE, WIDTH) - 16
) (
  input logic           clk_in,
  input logic           rst_in,
  dp_bram_fifo_if.slave bus
);

  localparam int DEPTH = fifo_depth(SIZE, WIDTH);
  localparam int ADDRW = fifo_addrw(SIZE, WIDTH);

  localparam logic [ADDRW:0]   CNT_FULL  = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW:0]   CNT_AFULL = (ADDRW + 1)'(AFULL_LVL);
  localparam logic [ADDRW:0]   CNT_ONE   = (ADDRW + 1)'(1);
  localparam logic [ADDRW-1:0] PTR_ONE   = ADDRW'(1);

  // Registered control state and its next-state values.
  logic [ADDRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRW:0]   count_q, count_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;

  // Handshake decode and RAM port signals.
  logic             full;
  logic             push_acc;
  logic             pop_acc;
  logic             ram_wr_en;
  logic [ADDRW-1:0] ram_rd_addr;
  logic [WIDTH-1:0] ram_rd_data;

  // Full/empty come from the count alone; the pointers wrap with no extra bit.
  assign full     = (count_q == CNT_FULL);
  assign push_acc = bus.push_in && !full;
  assign pop_acc  = bus.pop_in && valid_q;

  // Flush and reset discard a same-cycle push, so it must not reach the RAM.
  assign ram_wr_en = push_acc && !bus.flush_in && !rst_in;

  // Look one word ahead on a pop so back-to-back pops stream one per cycle.
  assign ram_rd_addr = pop_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  // Next-state logic for pointers, count, output valid and overflow flag.
  // NOTE: every _d gets its hold value first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;

    if (bus.flush_in) begin
      // Flush empties the FIFO but deliberately keeps the overflow history.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      // The word read on this edge is good only if it was already stored
      // before the edge: a word written on the same edge is not forwarded,
      // which is what produces the one-cycle bubble after an empty FIFO.
      if (pop_acc) begin
        valid_d = (count_q > CNT_ONE);
      end else begin
        valid_d = (count_q != '0);
      end

      if (bus.push_in && full) begin
        overflow_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset; reset outranks flush, push and pop.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  dp_bram #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_ram (
    .clk_in      (clk_in),
    .wr_en_in    (ram_wr_en),
    .wr_addr_in  (wr_ptr_q),
    .wr_data_in  (bus.push_data_in),
    .rd_addr_in  (ram_rd_addr),
    .rd_data_out (ram_rd_data)
  );

  assign bus.push_ready_out = !full;
  assign bus.pop_valid_out  = valid_q;
  assign bus.pop_data_out   = ram_rd_data;
  assign bus.count_out      = count_q;
  assign bus.afull_out      = (count_q >= CNT_AFULL);
  assign bus.overflow_out   = overflow_q;

endmodule

// File: tb/tb_dp_bram_fifo.sv
// Self-checking bench for dp_bram_fifo (WIDTH=8, SIZE=4096, DEPTH=512).
// A queue-based model with per-word push timestamps predicts every output;
// directed phases add literal expectations at the corner cases.
module tb_dp_bram_fifo;

  localparam int WIDTH     = 8;
  localparam int SIZE      = 4096;
  localparam int DEPTH     = 512;
  localparam int AFULL_LVL = 496;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dp_bram_fifo_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus_if ();

  dp_bram_fifo #(
    .WIDTH     (WIDTH),
    .SIZE      (SIZE),
    .AFULL_LVL (AFULL_LVL)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_if)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stored words in order, each tagged with the edge
  // number that wrote it. The head is presentable once it was stored
  // before the most recent edge.
  logic [7:0] m_word [$];
  int         m_stamp [$];
  bit         m_ovf;
  bit         m_valid;
  int         edge_n;

  initial begin
    bit pop_ok;
    bit push_ok;
    edge_n  = 0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        m_word.delete();
        m_stamp.delete();
        m_ovf = 1'b0;
      end else if (bus_if.flush_in) begin
        m_word.delete();
        m_stamp.delete();
      end else begin
        pop_ok  = bus_if.pop_in && m_valid;
        push_ok = bus_if.push_in && (m_word.size() < DEPTH);
        if (bus_if.push_in && !push_ok) m_ovf = 1'b1;
        if (pop_ok) begin
          void'(m_word.pop_front());
          void'(m_stamp.pop_front());
        end
        if (push_ok) begin
          m_word.push_back(bus_if.push_data_in);
          m_stamp.push_back(edge_n);
        end
      end
      m_valid = (m_word.size() > 0) ? (m_stamp[0] < edge_n) : 1'b0;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("model count",    32'(bus_if.count_out), 32'(m_word.size()));
        check("model ready",    32'(bus_if.push_ready_out), 32'(m_word.size() != DEPTH));
        check("model afull",    32'(bus_if.afull_out), 32'(m_word.size() >= AFULL_LVL));
        check("model overflow", 32'(bus_if.overflow_out), 32'(m_ovf));
        check("model valid",    32'(bus_if.pop_valid_out), 32'(m_valid));
        if (m_valid) check("model data", 32'(bus_if.pop_data_out), 32'(m_word[0]));
      end
    end
  end

  // Apply one cycle of stimulus, then return just after the rising edge.
  task automatic drive(input bit push, input logic [7:0] d, input bit pop, input bit flush);
    bus_if.push_in      = push;
    bus_if.push_data_in = d;
    bus_if.pop_in       = pop;
    bus_if.flush_in     = flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_word;
    int guard;
    bus_if.push_in      = 1'b0;
    bus_if.push_data_in = '0;
    bus_if.pop_in       = 1'b0;
    bus_if.flush_in     = 1'b0;

    // Reset state.
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("reset count",    32'(bus_if.count_out), 0);
    check("reset ready",    32'(bus_if.push_ready_out), 1);
    check("reset valid",    32'(bus_if.pop_valid_out), 0);
    check("reset afull",    32'(bus_if.afull_out), 0);
    check("reset overflow", 32'(bus_if.overflow_out), 0);

    // Single word into an empty FIFO: count now, valid one edge later.
    drive(1, 8'h11, 0, 0);
    check("first push count", 32'(bus_if.count_out), 1);
    check("first push valid", 32'(bus_if.pop_valid_out), 0);
    drive(0, 8'h00, 0, 0);
    check("first word valid", 32'(bus_if.pop_valid_out), 1);
    check("first word data",  32'(bus_if.pop_data_out), 32'h11);
    drive(0, 8'h00, 1, 0);
    check("first pop count", 32'(bus_if.count_out), 0);
    check("first pop valid", 32'(bus_if.pop_valid_out), 0);

    // Fill to full, crossing the almost-full threshold.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 8'(i), 0, 0);
      if (i == AFULL_LVL - 2) check("afull below level", 32'(bus_if.afull_out), 0);
      if (i == AFULL_LVL - 1) check("afull at level",    32'(bus_if.afull_out), 1);
    end
    check("full count",    32'(bus_if.count_out), DEPTH);
    check("full ready",    32'(bus_if.push_ready_out), 0);
    check("full afull",    32'(bus_if.afull_out), 1);
    check("full overflow", 32'(bus_if.overflow_out), 0);
    drive(1, 8'hEE, 0, 0);
    check("overflow set",   32'(bus_if.overflow_out), 1);
    check("overflow count", 32'(bus_if.count_out), DEPTH);

    // Push and pop together while full: pop wins, push dropped.
    check("full head valid", 32'(bus_if.pop_valid_out), 1);
    check("full head data",  32'(bus_if.pop_data_out), 0);
    drive(1, 8'hAA, 1, 0);
    check("full pushpop count", 32'(bus_if.count_out), DEPTH - 1);
    check("full pushpop ready", 32'(bus_if.push_ready_out), 1);

    // Drain: remaining words are 1..511 mod 256, with no trace of 0xAA.
    exp_word = 1;
    guard = 0;
    while (bus_if.count_out != 0 && guard < 2000) begin
      if (bus_if.pop_valid_out) begin
        check("drain word", 32'(bus_if.pop_data_out), 32'(exp_word & 8'hFF));
        exp_word++;
      end
      drive(0, 8'h00, 1, 0);
      guard++;
    end
    check("drain bounded", 32'(guard < 2000), 1);
    check("drain words",   32'(exp_word), DEPTH);

    // Flush with five words stored and a same-cycle push.
    for (int i = 0; i < 5; i++) drive(1, 8'(8'h30 + i), 0, 0);
    check("pre-flush count", 32'(bus_if.count_out), 5);
    drive(1, 8'h55, 0, 1);
    check("flush count",    32'(bus_if.count_out), 0);
    check("flush valid",    32'(bus_if.pop_valid_out), 0);
    check("flush overflow", 32'(bus_if.overflow_out), 1);
    drive(0, 8'h00, 0, 0);
    check("post-flush count", 32'(bus_if.count_out), 0);

    // Reset clears the sticky overflow.
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    rst = 1'b0;
    check("reset clears overflow", 32'(bus_if.overflow_out), 0);

    // Continuous streaming through pointer wrap.
    for (int i = 0; i < 1500; i++) begin
      drive(1, 8'($urandom), 1, 0);
      if (i >= 1) begin
        check("stream count range",
              32'(bus_if.count_out >= 1 && bus_if.count_out <= 2), 1);
      end
    end
    guard = 0;
    while (bus_if.count_out != 0 && guard < 20) begin
      drive(0, 8'h00, 1, 0);
      guard++;
    end
    check("stream drained", 32'(bus_if.count_out), 0);

    // Random push/pop at 50% with rare flushes.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 999) == 0));
    end

    // Push-heavy random traffic so full, almost-full and overflow occur.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
